// File: rtl/sr_drv_pkg.sv
// Shared types and command encoding for the SR flip-flop driver.
// A command is the {S,R} pair driven to the flop for one cycle.
package sr_drv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } state_t;

  localparam logic [1:0] CMD_HOLD    = 2'b00;
  localparam logic [1:0] CMD_RESET   = 2'b01;
  localparam logic [1:0] CMD_SET     = 2'b10;
  localparam logic [1:0] CMD_INVALID = 2'b11;

  // Move the flop only when the target differs from its believed state.
  function automatic logic [1:0] encode_cmd(input logic tgt, input logic q);
    if (tgt == q) return CMD_HOLD;
    return tgt ? CMD_SET : CMD_RESET;
  endfunction

endpackage

// File: rtl/sr_tgt_fifo.sv
// 1-bit synchronous FIFO holding pending target Q values.
// Pointers carry one extra wrap bit to tell full from empty.
module sr_tgt_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic          mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is data only; stale entries are unreachable after reset.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sr_ff_driver.sv
// Drives an SR flop from a stream of target Q values and checks Q after
// a settle window; S and R are registered and never both high.
module sr_ff_driver
  import sr_drv_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic             tgt_data,
  output logic             tgt_ready,
  output logic             S,
  output logic             R,
  input  logic             q_fb,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t            state;
  logic [1:0]        cmd;
  logic              q_model;
  logic              cur_tgt;
  logic [SC_W-1:0]   settle_cnt;

  logic              fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign tgt_ready = !fifo_full;
  assign push      = tgt_valid && tgt_ready;
  assign pop       = ((state == ST_IDLE) || (state == ST_CHECK)) && !fifo_empty;

  sr_tgt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (tgt_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign S        = cmd[1];
  assign R        = cmd[0];
  assign busy     = (state != ST_IDLE) || !fifo_empty;
  assign done     = (state == ST_CHECK);
  assign mismatch = done && (q_fb != cur_tgt);

  // The command is registered on the edge that enters DRIVE, so it is
  // visible for exactly the DRIVE cycle. From CHECK, q_fb is the fresh
  // flop state that q_model is about to take.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cmd        <= CMD_HOLD;
      q_model    <= 1'b0;
      err_cnt    <= '0;
      settle_cnt <= '0;
    end else begin
      cmd <= CMD_HOLD;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state <= ST_DRIVE;
            cmd   <= encode_cmd(fifo_dout, q_model);
          end
        end
        ST_DRIVE: begin
          settle_cnt <= '0;
          state      <= (SETTLE > 0) ? ST_SETTLE : ST_CHECK;
        end
        ST_SETTLE: begin
          if (int'(settle_cnt) >= SETTLE - 1) state <= ST_CHECK;
          else                                settle_cnt <= settle_cnt + 1'b1;
        end
        ST_CHECK: begin
          q_model <= q_fb;
          if (q_fb != cur_tgt) err_cnt <= sat_inc(err_cnt);
          if (!fifo_empty) begin
            state <= ST_DRIVE;
            cmd   <= encode_cmd(fifo_dout, q_fb);
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (pop) cur_tgt <= fifo_dout;
  end

  a_no_invalid_cmd: assert property (@(posedge clk) disable iff (!rst) cmd != CMD_INVALID);

endmodule

// File: tb/tb_sr_ff_driver.sv
// Scoreboard bench for sr_ff_driver with an attached behavioural SR flop.
// Expected commands/mismatches are queued on acceptance and popped on done.
module tb_sr_ff_driver;

  localparam int DEPTH  = 4;
  localparam int SETTLE = 1;
  localparam int CNT_W  = 2;
  localparam int ERR_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tgt_valid = 1'b0;
  logic tgt_data = 1'b0;
  logic tgt_ready, S, R, q_fb, busy, done, mismatch;
  logic [CNT_W-1:0] err_cnt;

  logic flop_q;
  logic stuck = 1'b0;

  typedef struct packed {
    logic [1:0] cmd;
    logic       mis;
  } exp_t;

  exp_t exp_q[$];
  logic mq = 1'b0;
  int   err_exp = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;
  logic [1:0] hist [0:7];

  always #5 clk = ~clk;

  sr_ff_driver #(.DEPTH(DEPTH), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .tgt_valid (tgt_valid),
    .tgt_data  (tgt_data),
    .tgt_ready (tgt_ready),
    .S         (S),
    .R         (R),
    .q_fb      (q_fb),
    .busy      (busy),
    .done      (done),
    .mismatch  (mismatch),
    .err_cnt   (err_cnt)
  );

  // Behavioural SR flop, reset to 0 together with the driver.
  always @(posedge clk or negedge rst) begin
    if (!rst)          flop_q <= 1'b0;
    else if (S && !R)  flop_q <= 1'b1;
    else if (R && !S)  flop_q <= 1'b0;
  end
  assign q_fb = stuck ? 1'b0 : flop_q;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: the flop is expected to hold the previous target (or 0 when
  // stuck); a command is needed only when the new target differs.
  always @(posedge clk) begin : accept_mon
    exp_t e;
    if (rst && tgt_valid && tgt_ready) begin
      if (tgt_data == mq) e.cmd = 2'b00;
      else                e.cmd = tgt_data ? 2'b10 : 2'b01;
      e.mis = stuck && tgt_data;
      mq = stuck ? 1'b0 : tgt_data;
      if (e.mis && err_exp < ERR_MAX) err_exp++;
      exp_q.push_back(e);
    end
  end

  always @(negedge clk) begin : out_mon
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < 8; i++) hist[i] = 2'b00;
    end else begin
      chk("s_and_r", int'(S & R), 0);
      if (done) begin
        done_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("cmd", int'(hist[SETTLE]), int'(e.cmd));
          chk("mismatch", int'(mismatch), int'(e.mis));
        end
      end else begin
        chk("mismatch_no_done", int'(mismatch), 0);
      end
      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {S, R};
    end
  end

  task automatic push(input logic v);
    int n;
    tgt_valid = 1'b1;
    tgt_data  = v;
    n = 0;
    while (!tgt_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      errors++;
      $display("FAIL push_timeout actual=ready_low required=ready_high");
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    tgt_valid = 1'b0;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", int'(n >= 300), 0);
    chk("drain_queue", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    mq = 1'b0;
    err_exp = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int base;
    int low;
    int n;

    // Reset and idle
    repeat (2) @(negedge clk);
    chk("rst_S", int'(S), 0);
    chk("rst_R", int'(R), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(tgt_ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err_cnt), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_S", int'(S), 0);
    chk("idle_R", int'(R), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_ready", int'(tgt_ready), 1);

    // Set then reset, with latency checks
    base = done_seen;
    push(1'b1);
    tgt_data = 1'b0;
    @(negedge clk);
    tgt_valid = 1'b0;
    chk("set_pulse_S", int'(S), 1);
    chk("set_pulse_R", int'(R), 0);
    repeat (SETTLE + 2) @(negedge clk);
    chk("reset_pulse_S", int'(S), 0);
    chk("reset_pulse_R", int'(R), 1);
    drain();
    chk("setreset_dones", done_seen - base, 2);
    chk("setreset_err", int'(err_cnt), 0);

    // Hold and sequence
    base = done_seen;
    push(1'b1); push(1'b1); push(1'b0); push(1'b0); push(1'b1);
    drain();
    chk("seq_dones", done_seen - base, 5);
    chk("seq_err", int'(err_cnt), 0);

    // Stuck flop and saturation
    do_reset();
    stuck = 1'b1;
    push(1'b1); push(1'b1); push(1'b1);
    drain();
    chk("stuck_err3", int'(err_cnt), 3);
    push(1'b1); push(1'b1);
    drain();
    chk("stuck_sat", int'(err_cnt), ERR_MAX);
    chk("stuck_model", int'(err_cnt), err_exp);
    stuck = 1'b0;
    do_reset();

    // Backpressure
    push(1'b1);
    low = 0;
    tgt_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tgt_data = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!tgt_ready) low++;
    end
    tgt_valid = 1'b0;
    chk("bp_ready_dropped", int'(low > 0), 1);
    drain();
    chk("bp_err", int'(err_cnt), 0);

    // Randomized traffic
    for (int i = 0; i < 120; i++) begin
      tgt_valid = 1'($urandom_range(0, 1));
      tgt_data  = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    drain();
    chk("rand_err", int'(err_cnt), 0);

    // Reset during SETTLE of the second of four targets
    do_reset();
    push(1'b1); push(1'b0); push(1'b1); push(1'b0);
    tgt_valid = 1'b0;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_first_done", int'(done), 1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    mq = 1'b0;
    err_exp = 0;
    #1;
    chk("mid_S", int'(S), 0);
    chk("mid_R", int'(R), 0);
    chk("mid_done", int'(done), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_ready", int'(tgt_ready), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_busy", int'(busy), 0);
    chk("post_err", int'(err_cnt), 0);
    push(1'b1);
    tgt_valid = 1'b0;
    @(negedge clk);
    chk("post_set_S", int'(S), 1);
    chk("post_set_R", int'(R), 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
